// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel dead-time PWM: counting modes,
// counter direction and width helpers.
package pwm_pkg;

    localparam int WIDTH_DEF   = 11;
    localparam int MODE_EDGE   = 0;
    localparam int MODE_CENTER = 1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    function automatic int max_of(input int width);
        return (1 << width) - 1;
    endfunction

    // Dead counter must hold the value DEAD itself; keep at least one bit for DEAD=0.
    function automatic int dead_w(input int dead);
        return (dead < 1) ? 1 : $clog2(dead + 1);
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// One complementary gate pair: registers the raw compare and only asserts a
// side once raw has held its level for DEAD consecutive cycles.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DEAD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic raw,
    output logic pwm_hi,
    output logic pwm_lo
);

    localparam int CW = dead_w(DEAD);
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD);

    logic          raw_q;
    logic [CW-1:0] run;
    logic [CW-1:0] run_d;

    // Length of the current constant-raw run, saturating at DEAD; any change restarts it.
    always_comb begin
        run_d = '0;
        if (raw == raw_q) begin
            if (run != DEAD_C) begin
                run_d = run + 1'b1;
            end else begin
                run_d = run;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q  <= 1'b0;
            run    <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            raw_q <= raw;
            if (!en) begin
                run    <= '0;
                pwm_hi <= 1'b0;
                pwm_lo <= 1'b0;
            end else begin
                run    <= run_d;
                pwm_hi <= raw && (run_d == DEAD_C);
                pwm_lo <= !raw && (run_d == DEAD_C);
            end
        end
    end

endmodule

// File: rtl/pwm_multi_dt.sv
// NUM_CH PWM channels on one shared edge- or centre-aligned period counter,
// with double-buffered duties loaded at the period boundary.
module pwm_multi_dt
    import pwm_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int NUM_CH = 2,
    parameter int CENTER = MODE_EDGE,
    parameter int DEAD   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_CH*WIDTH-1:0] duty_in,
    input  logic [NUM_CH-1:0]       duty_wr,
    output logic [NUM_CH-1:0]       pwm_hi,
    output logic [NUM_CH-1:0]       pwm_lo,
    output logic                    period_start
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(max_of(WIDTH));

    logic [WIDTH-1:0] cnt;
    dir_t             dir;
    logic             boundary;

    // A parked counter sits at 0, so the first enabled cycle is a boundary.
    assign boundary = en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            dir          <= DIR_UP;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            if (!en) begin
                cnt <= '0;
                dir <= DIR_UP;
            end else if (CENTER == MODE_EDGE) begin
                cnt <= cnt + 1'b1;
            end else if (dir == DIR_UP) begin
                if (cnt == MAX) begin
                    cnt <= cnt - 1'b1;
                    dir <= DIR_DOWN;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                if (cnt == WIDTH'(1)) begin
                    cnt <= '0;
                    dir <= DIR_UP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [WIDTH-1:0] shadow;
        logic [WIDTH-1:0] active;
        logic [WIDTH-1:0] load;
        logic [WIDTH-1:0] eff;
        logic             raw_d;

        // A write landing on the boundary cycle bypasses the shadow.
        assign load  = duty_wr[c] ? duty_in[c*WIDTH +: WIDTH] : shadow;
        // Compare the boundary cycle against the incoming duty so the whole new period uses it.
        assign eff   = boundary ? load : active;
        assign raw_d = (eff == MAX) || (cnt < eff);

        always_ff @(posedge clk) begin
            if (rst) begin
                shadow <= '0;
                active <= '0;
            end else begin
                if (duty_wr[c]) begin
                    shadow <= duty_in[c*WIDTH +: WIDTH];
                end
                if (boundary) begin
                    active <= load;
                end
            end
        end

        pwm_deadtime #(
            .DEAD (DEAD)
        ) u_dt (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .raw    (raw_d),
            .pwm_hi (pwm_hi[c]),
            .pwm_lo (pwm_lo[c])
        );
    end

endmodule

// File: tb/tb_pwm_multi_dt.sv
// Bench for pwm_multi_dt: edge (DEAD=3), centre (DEAD=3) and edge (DEAD=0)
// instances checked against pulse-width formulas.
module tb_pwm_multi_dt;

    localparam int W    = 8;
    localparam int MAXV = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       e_en = 1'b0, c_en = 1'b0;
    logic [15:0] e_duty = '0, c_duty = '0;
    logic [1:0] e_wr = '0, c_wr = '0;
    logic [1:0] e_hi, e_lo, c_hi, c_lo, z_hi, z_lo;
    logic       e_ps, c_ps, z_ps;

    int checks = 0;
    int passes = 0;
    int overlap = 0;
    int z_bad = 0;
    logic z_live = 1'b0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    pwm_multi_dt #(.WIDTH(W), .NUM_CH(2), .CENTER(0), .DEAD(3)) u_edge (
        .clk(clk), .rst(rst), .en(e_en), .duty_in(e_duty), .duty_wr(e_wr),
        .pwm_hi(e_hi), .pwm_lo(e_lo), .period_start(e_ps));

    pwm_multi_dt #(.WIDTH(W), .NUM_CH(2), .CENTER(1), .DEAD(3)) u_ctr (
        .clk(clk), .rst(rst), .en(c_en), .duty_in(c_duty), .duty_wr(c_wr),
        .pwm_hi(c_hi), .pwm_lo(c_lo), .period_start(c_ps));

    pwm_multi_dt #(.WIDTH(W), .NUM_CH(2), .CENTER(0), .DEAD(0)) u_zero (
        .clk(clk), .rst(rst), .en(e_en), .duty_in(e_duty), .duty_wr(e_wr),
        .pwm_hi(z_hi), .pwm_lo(z_lo), .period_start(z_ps));

    // Invariant monitors: never both sides on; DEAD=0 pair is exact complement while running.
    always @(posedge clk) z_live <= e_en && !rst;
    always @(negedge clk) begin
        if (((e_hi & e_lo) | (c_hi & c_lo) | (z_hi & z_lo)) != 2'b00) overlap <= overlap + 1;
        if (z_live && (z_hi !== ~z_lo)) z_bad <= z_bad + 1;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int period_of(input int inst);
        return (inst == 1) ? 2 * MAXV : MAXV + 1;
    endfunction

    function automatic int dead_of(input int inst);
        return (inst == 2) ? 0 : 3;
    endfunction

    function automatic int raw_len(input int inst, input int d);
        if (d == 0) return 0;
        if (d == MAXV) return period_of(inst);
        return (inst == 1) ? 2 * d - 1 : d;
    endfunction

    function automatic int on_time(input int t, input int dead);
        return (t > dead) ? t - dead : 0;
    endfunction

    task automatic push_expect(input int inst, input int d);
        int t;
        t = raw_len(inst, d);
        exp_q.push_back(16'(on_time(t, dead_of(inst))));
        exp_q.push_back(16'(dead_of(inst)));
        exp_q.push_back(16'(on_time(period_of(inst) - t, dead_of(inst))));
        exp_q.push_back(16'(dead_of(inst)));
    endtask

    // ---------------- DUT observation ----------------
    function automatic logic get_sig(input int inst, input int ch, input int which);
        logic [1:0] v;
        case (inst)
            0:       v = (which != 0) ? e_lo : e_hi;
            1:       v = (which != 0) ? c_lo : c_hi;
            default: v = (which != 0) ? z_lo : z_hi;
        endcase
        return v[ch];
    endfunction

    function automatic logic get_ps(input int inst);
        return (inst == 1) ? c_ps : e_ps;
    endfunction

    task automatic wait_level(input int inst, input int ch, input int which, input logic lvl, output bit ok);
        int n;
        n = 0;
        while (get_sig(inst, ch, which) !== lvl && n < 1500) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 1500);
    endtask

    task automatic count_run(input int inst, input int ch, input int which, output int n);
        n = 0;
        while (get_sig(inst, ch, which) === 1'b1 && n < 1500) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_gap(input int inst, input int ch, output int n);
        n = 0;
        while (get_sig(inst, ch, 0) === 1'b0 && get_sig(inst, ch, 1) === 1'b0 && n < 1500) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Widths of one hi pulse, the following gap, lo pulse and gap.
    task automatic measure(input int inst, input int ch, output int got[4], output bit ok);
        bit ok1, ok2;
        wait_level(inst, ch, 0, 1'b0, ok1);
        wait_level(inst, ch, 0, 1'b1, ok2);
        ok = ok1 && ok2;
        count_run(inst, ch, 0, got[0]);
        count_gap(inst, ch, got[1]);
        count_run(inst, ch, 1, got[2]);
        count_gap(inst, ch, got[3]);
    endtask

    task automatic wait_ps(input int inst, output bit ok);
        int n;
        n = 0;
        while (get_ps(inst) !== 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 1200);
        @(negedge clk);
    endtask

    task automatic write_duty(input int inst, input int ch, input int d);
        if (inst == 1) begin
            c_duty[ch*W +: W] = W'(d);
            c_wr = 2'(1 << ch);
            @(negedge clk);
            c_wr = '0;
        end else begin
            e_duty[ch*W +: W] = W'(d);
            e_wr = 2'(1 << ch);
            @(negedge clk);
            e_wr = '0;
        end
    endtask

    task automatic settle(input int inst);
        bit ok;
        wait_ps(inst, ok);
        wait_ps(inst, ok);
        checks++;
        if (!ok) $display("FAIL settle inst%0d: period_start seen %0d required 1", inst, ok);
        else passes++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({e_hi, e_lo, e_ps, c_hi, c_lo, c_ps, z_hi, z_lo} !== '0)
            $display("FAIL reset_outputs: got %b required 0", {e_hi, e_lo, e_ps, c_hi, c_lo, c_ps, z_hi, z_lo});
        else passes++;
        rst = 1'b0;
        e_en = 1'b1;
        @(negedge clk);
        checks++;
        if (e_ps !== 1'b1) $display("FAIL first_enable_ps: got %b required 1", e_ps);
        else passes++;
        checks++;
        if (z_lo !== 2'b11) $display("FAIL dead0_lo_immediate: got %b required 11", z_lo);
        else passes++;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (e_lo !== ((k == 3) ? 2'b11 : 2'b00))
                $display("FAIL lo_after_en cycle %0d: got %b required %b", k, e_lo, (k == 3) ? 2'b11 : 2'b00);
            else passes++;
            if (k < 3) @(negedge clk);
        end
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (e_hi !== 2'b00 || e_lo !== 2'b11) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL zero_duty_steady: bad cycles %0d required 0", bad);
        else passes++;
        checks++;
        if ({c_hi, c_lo} !== '0) $display("FAIL center_parked: got %b required 0", {c_hi, c_lo});
        else passes++;
    endtask

    task automatic test_period_len(input int inst);
        bit ok;
        int n;
        wait_ps(inst, ok);
        n = 1;
        while (get_ps(inst) !== 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ok || n !== period_of(inst))
            $display("FAIL period_len inst%0d: got %0d required %0d", inst, n, period_of(inst));
        else passes++;
    endtask

    task automatic check_pulses(input int inst, input int ch, input int d, input string tag);
        int got[4];
        bit ok;
        logic [15:0] e;
        push_expect(inst, d);
        measure(inst, ch, got, ok);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (!ok || got[k] !== int'(e))
                $display("FAIL %s inst%0d ch%0d d=%0d field%0d: got %0d required %0d", tag, inst, ch, d, k, got[k], e);
            else passes++;
        end
    endtask

    task automatic test_edge_duty();
        write_duty(0, 0, 64);
        settle(0);
        check_pulses(0, 0, 64, "edge64");
        check_pulses(2, 0, 64, "dead0_64");
        test_period_len(0);
    endtask

    task automatic test_random_duty();
        int d, ch;
        for (int it = 0; it < 4; it++) begin
            d = $urandom_range(4, MAXV - 4);
            ch = $urandom_range(0, 1);
            write_duty(0, ch, d);
            settle(0);
            check_pulses(0, ch, d, "edge_rand");
            check_pulses(2, ch, d, "dead0_rand");
        end
    endtask

    task automatic test_shadow_defer();
        bit ok;
        int bad, n;
        write_duty(0, 1, 0);
        settle(0);
        wait_ps(0, ok);
        repeat (50) @(negedge clk);
        write_duty(0, 1, 0);
        repeat (10) @(negedge clk);
        write_duty(0, 1, MAXV);
        bad = 0;
        n = 0;
        while (e_ps !== 1'b1 && n < 1200) begin
            if (e_hi[1] !== 1'b0 || e_lo[1] !== 1'b1) bad++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (bad !== 0 || n >= 1200) $display("FAIL shadow_defer: bad cycles %0d (wait %0d) required 0", bad, n);
        else passes++;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({e_hi[1], e_lo[1]} !== ((k == 3) ? 2'b10 : 2'b00))
                $display("FAIL full_duty_entry cycle %0d: got %b required %b", k, {e_hi[1], e_lo[1]}, (k == 3) ? 2'b10 : 2'b00);
            else passes++;
            @(negedge clk);
        end
        bad = 0;
        repeat (600) begin
            if (e_hi[1] !== 1'b1 || e_lo[1] !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) $display("FAIL full_duty_steady: bad cycles %0d required 0", bad);
        else passes++;
    endtask

    task automatic test_bypass();
        int n;
        n = 0;
        while (e_ps !== 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        repeat (MAXV) @(negedge clk);
        checks++;
        if (e_ps !== 1'b0) $display("FAIL ps_before_boundary: got %b required 0", e_ps);
        else passes++;
        e_duty[7:0] = 8'd128;
        e_wr = 2'b01;
        @(negedge clk);
        e_wr = 2'b00;
        checks++;
        if (e_ps !== 1'b1) $display("FAIL ps_at_boundary: got %b required 1", e_ps);
        else passes++;
        fork
            begin
                repeat (40) @(negedge clk);
                e_duty[7:0] = 8'd10;
                e_wr = 2'b01;
                @(negedge clk);
                e_wr = 2'b00;
            end
        join_none
        check_pulses(0, 0, 128, "bypass128");
        check_pulses(0, 0, 10, "deferred10");
    endtask

    task automatic test_center();
        write_duty(1, 0, 100);
        c_en = 1'b1;
        settle(1);
        test_period_len(1);
        check_pulses(1, 0, 100, "center100");
        begin
            int d;
            d = $urandom_range(4, MAXV - 5);
            write_duty(1, 1, d);
            settle(1);
            check_pulses(1, 1, d, "center_rand");
        end
    endtask

    task automatic test_glitch();
        bit ok;
        int hi_n, lo_n, z_n;
        write_duty(0, 1, 2);
        settle(0);
        wait_ps(0, ok);
        hi_n = 0;
        lo_n = 0;
        z_n = 0;
        repeat (MAXV + 1) begin
            if (e_hi[1] === 1'b1) hi_n++;
            if (e_lo[1] === 1'b1) lo_n++;
            if (z_hi[1] === 1'b1) z_n++;
            @(negedge clk);
        end
        checks++;
        if (hi_n !== on_time(raw_len(0, 2), 3)) $display("FAIL glitch_hi: got %0d required 0", hi_n);
        else passes++;
        checks++;
        if (lo_n !== MAXV + 1 - raw_len(0, 2) - 3) $display("FAIL glitch_lo: got %0d required %0d", lo_n, MAXV + 1 - 2 - 3);
        else passes++;
        checks++;
        if (z_n !== raw_len(0, 2)) $display("FAIL glitch_dead0_hi: got %0d required 2", z_n);
        else passes++;
    endtask

    task automatic test_en_rst_midperiod();
        bit ok;
        int bad;
        write_duty(0, 0, 128);
        settle(0);
        wait_level(0, 0, 0, 1'b1, ok);
        repeat (5) @(negedge clk);
        e_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({e_hi, e_lo, e_ps, z_hi, z_lo} !== '0 || !ok)
            $display("FAIL en_low_safe: got %b required 0", {e_hi, e_lo, e_ps, z_hi, z_lo});
        else passes++;
        write_duty(0, 0, 200);
        repeat (10) @(negedge clk);
        e_en = 1'b1;
        settle(0);
        check_pulses(0, 0, 200, "shadow_while_parked");
        wait_level(0, 0, 0, 1'b1, ok);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({e_hi, e_lo, e_ps, c_hi, c_lo, c_ps, z_hi, z_lo} !== '0 || !ok)
            $display("FAIL reset_midperiod: got %b required 0", {e_hi, e_lo, e_ps, c_hi, c_lo, c_ps, z_hi, z_lo});
        else passes++;
        rst = 1'b0;
        bad = 0;
        repeat (600) begin
            @(negedge clk);
            if (e_hi !== 2'b00 || z_hi !== 2'b00 || c_hi !== 2'b00) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL shadow_lost_on_reset: bad cycles %0d required 0", bad);
        else passes++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_edge_duty();
        test_random_duty();
        test_shadow_defer();
        test_bypass();
        test_center();
        test_glitch();
        test_en_rst_midperiod();
        @(negedge clk);
        checks++;
        if (overlap !== 0) $display("FAIL hi_lo_overlap: cycles %0d required 0", overlap);
        else passes++;
        checks++;
        if (z_bad !== 0) $display("FAIL dead0_complement: cycles %0d required 0", z_bad);
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
